ps2_paddle_cmd: RTL and testbench
=================================

Name: ps2_paddle_cmd

Overview:
Receives PS/2 keyboard frames and turns key make/break codes into paddle movement commands. Output is a direction code plus a rate-limited one-cycle enable pulse, for the paddle position register, which consumes them on `clock`. Holding a key produces one movement step per tick period; releasing it stops movement. Sits between the board PS/2 pins and the paddle controller.

Parameters:
TICK_DIV, 833333, clock cycles per movement tick (50 MHz / 60 Hz); sims use 4
TIMEOUT, 50000, clock cycles without a PS/2 falling edge before an in-progress frame is aborted
KEY_LEFT, 8'h1C, non-extended make code for left ("A")
KEY_RIGHT, 8'h23, non-extended make code for right ("D")

Ports:
clock  input  1  system clock
resetn  input  1  synchronous, active-low reset
ps2_clk  input  1  raw PS/2 clock pin, asynchronous
ps2_dat  input  1  raw PS/2 data pin, asynchronous
cmd  output  8  8'h00 = move right, 8'h01 = move left, 8'hFF = no command
cmdEnable  output  1  one-cycle pulse: cmd is valid, apply one step
left_held  output  1  left key currently held
right_held  output  1  right key currently held
frame_err  output  1  one-cycle pulse on a parity, stop or timeout error

Behaviour:
- Reset: resetn is synchronous, active-low; clock is clock. On reset: cmd=8'hFF, cmdEnable=0, left_held=0, right_held=0, frame_err=0. Receiver FSM goes to IDLE; prefix flags, tick counter and timeout counter clear. Reset mid-frame discards the partial byte.
- Input sync: ps2_clk and ps2_dat each pass through a 2-flop synchronizer. A falling edge is synced clk previous=1, current=0. Data is sampled on the cycle the falling edge is detected.
- Receiver FSM, advancing only on falling edges:
  - IDLE: data=0 -> DATA with bit count 0. data=1 is a false start; stay in IDLE.
  - DATA: shift bits in LSB first. After the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: data=1 and odd parity over the 8 data bits plus parity bit -> byte_valid pulses for one cycle -> IDLE. Otherwise frame_err pulses, the byte is dropped -> IDLE.
- Timeout: in any state other than IDLE, the counter resets on every falling edge. If it reaches TIMEOUT-1, frame_err pulses, the FSM goes to IDLE and prefix flags clear.
- Decoder, acting on byte_valid:
  - 8'hE0 sets the ext flag.
  - 8'hF0 sets the brk flag.
  - Any other byte: left key = (!ext & byte==KEY_LEFT) | (ext & byte==8'h6B). Right key = (!ext & byte==KEY_RIGHT) | (ext & byte==8'h74). A matching key sets its held bit to !brk. Then ext and brk both clear, whether or not the key matched.
  - Held bits change the cycle after byte_valid.
- Any frame_err clears ext and brk. Held bits are not changed by an error.
- Tick: the counter counts 0..TICK_DIV-1 and wraps. On the wrap cycle, if exactly one held bit is set, the next cycle has cmdEnable=1 and cmd=8'h00 (right) or 8'h01 (left).
- Otherwise cmdEnable=0 and cmd=8'hFF. This covers both keys held (they cancel) and no key held.
- Between ticks: cmdEnable=0, cmd holds its last value.
- Pulse spacing: cmdEnable is never high on two consecutive cycles. Pulses are exactly TICK_DIV cycles apart while a key stays held.
- A key pressed and released entirely between two ticks produces no pulse.
- Typematic repeats (the keyboard resending the make code) leave the held bit at 1; no extra pulses.

Test Plan:
- Reset, then idle lines high for 3*TICK_DIV cycles (TICK_DIV=4) -> cmd=8'hFF, cmdEnable never 1, frame_err=0.
- Send frame 8'h1C, wait 12 cycles -> left_held=1; cmdEnable pulses every 4 cycles with cmd=8'h01. Send F0 then 1C -> left_held=0, pulses stop.
- Send E0 74 -> right_held=1; pulses carry cmd=8'h00. Send E0 F0 74 -> right_held=0. Send E0 1C -> no held bit changes.
- Hold both: send 1C then 23 -> left_held=1, right_held=1, no cmdEnable pulses. Send F0 23 -> left pulses (cmd=8'h01) resume at the next tick.
- Send 8'h1C with wrong parity -> frame_err pulses once, left_held stays 0. Send a frame with stop bit 0 -> frame_err pulses. Next valid 1C is accepted normally.
- Send 5 bits then stop toggling for TIMEOUT cycles -> frame_err pulses, FSM returns to IDLE, next full 23 frame sets right_held=1. Assert resetn=0 mid-frame -> all outputs return to reset values.

Source files
------------

// File: rtl/ps2_paddle_cmd.sv
// ps2_paddle_cmd: PS/2 keyboard receiver that turns A/D or arrow key make/break codes into rate-limited paddle step commands
module ps2_paddle_cmd #(
  parameter int         TICK_DIV  = 833333,
  parameter int         TIMEOUT   = 50000,
  parameter logic [7:0] KEY_LEFT  = 8'h1C,
  parameter logic [7:0] KEY_RIGHT = 8'h23
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] cmd,
  output logic       cmdEnable,
  output logic       left_held,
  output logic       right_held,
  output logic       frame_err
);
  localparam int TKW = $clog2(TICK_DIV + 1);
  localparam int TOW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  logic [2:0]     clk_sync_q;
  logic [1:0]     dat_sync_q;
  state_t         state_q;
  logic [2:0]     cnt_q;
  logic [7:0]     shift_q;
  logic           par_q;
  logic [TOW-1:0] to_q;
  logic           byte_valid_q;
  logic           frame_err_q;
  logic           ext_q;
  logic           brk_q;
  logic           left_q;
  logic           right_q;
  logic [TKW-1:0] tick_q;
  logic [TKW-1:0] tick_d;
  logic [7:0]     cmd_q;
  logic [7:0]     cmd_d;
  logic           en_q;
  logic           fall;
  logic           bit_in;
  logic           wrap;
  logic           one_held;
  logic           left_key;
  logic           right_key;
  assign fall      = clk_sync_q[2] & ~clk_sync_q[1];
  assign bit_in    = dat_sync_q[1];
  assign left_key  = (~ext_q & shift_q == KEY_LEFT) | (ext_q & shift_q == 8'h6B);
  assign right_key = (~ext_q & shift_q == KEY_RIGHT) | (ext_q & shift_q == 8'h74);
  assign wrap      = tick_q == TKW'(TICK_DIV - 1);
  assign one_held  = left_q ^ right_q;
  assign tick_d    = wrap ? '0 : tick_q + 1'b1;
  assign cmd_d     = !wrap ? cmd_q : !one_held ? 8'hFF : right_q ? 8'h00 : 8'h01;
  assign cmd        = cmd_q;
  assign cmdEnable  = en_q;
  assign left_held  = left_q;
  assign right_held = right_q;
  assign frame_err  = frame_err_q;
  // Two-flop synchronizers; the extra clock stage keeps the previous synced level for edge detection
  always_ff @(posedge clock) begin
    if (!resetn) begin
      clk_sync_q <= 3'b111;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[1:0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_dat};
    end
  end
  // Frame receiver: advances on PS/2 falling edges, aborts a stalled frame after the timeout
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      to_q         <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (state_q != IDLE && to_q == TOW'(TIMEOUT - 1)) begin
        frame_err_q <= 1'b1;
        state_q     <= IDLE;
        to_q        <= '0;
      end else if (fall) begin
        to_q <= '0;
        case (state_q)
          IDLE: if (!bit_in) begin
            state_q <= DATA;
            cnt_q   <= '0;
          end
          DATA: begin
            shift_q <= {bit_in, shift_q[7:1]};
            cnt_q   <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) state_q <= PARITY;
          end
          PARITY: begin
            par_q   <= bit_in;
            state_q <= STOP;
          end
          default: begin
            if (bit_in && ^{shift_q, par_q}) byte_valid_q <= 1'b1;
            else frame_err_q <= 1'b1;
            state_q <= IDLE;
          end
        endcase
      end else if (state_q != IDLE) begin
        to_q <= to_q + 1'b1;
      end
    end
  end
  // Scan-code decoder: E0/F0 prefixes qualify the next byte, which updates the matching held bit
  always_ff @(posedge clock) begin
    if (!resetn) begin
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
    end else if (frame_err_q) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else if (byte_valid_q) begin
      if (shift_q == 8'hE0) ext_q <= 1'b1;
      else if (shift_q == 8'hF0) brk_q <= 1'b1;
      else begin
        if (left_key) left_q <= ~brk_q;
        if (right_key) right_q <= ~brk_q;
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end
    end
  end
  // Movement tick: one step per period when exactly one key is held, both or none means no command
  always_ff @(posedge clock) begin
    if (!resetn) begin
      tick_q <= '0;
      cmd_q  <= 8'hFF;
      en_q   <= 1'b0;
    end else begin
      tick_q <= tick_d;
      cmd_q  <= cmd_d;
      en_q   <= wrap & one_held;
    end
  end
endmodule

// File: tb/tb_ps2_paddle_cmd.sv
// tb_ps2_paddle_cmd: scoreboard bench driving PS/2 frames and checking held bits, errors and step pulses
module tb_ps2_paddle_cmd;
  localparam int TD = 4;
  localparam int TO = 100;
  localparam int H  = 3;
  typedef struct {
    logic l;
    logic r;
    int   e;
  } fexp_t;
  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] cmd;
  logic       cmdEnable;
  logic       left_held;
  logic       right_held;
  logic       frame_err;
  int         n_vec = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         err_cnt = 0;
  int         last_pulse = -1;
  bit         mon_en = 1'b0;
  logic [7:0] exp_cmd_q[$];
  fexp_t      fq[$];
  logic       ml = 1'b0, mr = 1'b0, mext = 1'b0, mbrk = 1'b0;

  ps2_paddle_cmd #(.TICK_DIV(TD), .TIMEOUT(TO)) dut (
    .clock(clock), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .cmd(cmd), .cmdEnable(cmdEnable), .left_held(left_held),
    .right_held(right_held), .frame_err(frame_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    cyc++;
    if (frame_err) err_cnt++;
    if (mon_en && cmdEnable) begin
      check("pulse_expected", 32'(exp_cmd_q.size() > 0), 1);
      if (exp_cmd_q.size() > 0) check("pulse_cmd", cmd, exp_cmd_q.pop_front());
      if (last_pulse >= 0) check("pulse_spacing", cyc - last_pulse, TD);
      last_pulse = cyc;
    end
  end

  task automatic watch(input int n, input int np, input logic [7:0] c);
    repeat (np) exp_cmd_q.push_back(c);
    @(negedge clock);
    #1;
    last_pulse = -1;
    mon_en = 1'b1;
    repeat (n) @(negedge clock);
    #1;
    mon_en = 1'b0;
    check("missing_pulses", exp_cmd_q.size(), 0);
    exp_cmd_q.delete();
  endtask

  task automatic ps2_bit(input logic d);
    @(negedge clock);
    ps2_dat = d;
    repeat (H) @(negedge clock);
    ps2_clk = 1'b0;
    repeat (H) @(negedge clock);
    ps2_clk = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input int kind);
    int    e0;
    fexp_t x;
    logic  p;
    logic  lk, rk;
    e0 = err_cnt;
    p = (kind == 1) ? ^b : ~^b;
    if (kind != 0) begin
      mext = 1'b0;
      mbrk = 1'b0;
    end else if (b == 8'hE0) mext = 1'b1;
    else if (b == 8'hF0) mbrk = 1'b1;
    else begin
      lk = mext ? (b == 8'h6B) : (b == 8'h1C);
      rk = mext ? (b == 8'h74) : (b == 8'h23);
      if (lk) ml = !mbrk;
      if (rk) mr = !mbrk;
      mext = 1'b0;
      mbrk = 1'b0;
    end
    x.l = ml;
    x.r = mr;
    x.e = (kind != 0) ? 1 : 0;
    fq.push_back(x);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(p);
    ps2_bit(kind != 2);
    ps2_dat = 1'b1;
    repeat (8) @(negedge clock);
    x = fq.pop_front();
    check($sformatf("left_held_after_%h", b), left_held, x.l);
    check($sformatf("right_held_after_%h", b), right_held, x.r);
    check($sformatf("frame_err_after_%h", b), err_cnt - e0, x.e);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    int e0;
    repeat (3) @(negedge clock);
    check("rst_cmd", cmd, 8'hFF);
    check("rst_en", cmdEnable, 0);
    check("rst_left", left_held, 0);
    check("rst_right", right_held, 0);
    check("rst_err", frame_err, 0);
    resetn = 1'b1;
    watch(3 * TD, 0, 8'h00);
    check("idle_cmd", cmd, 8'hFF);
    check("idle_err", err_cnt, 0);
    send(8'h1C, 0);
    watch(12, 3, 8'h01);
    check("left_cmd_hold", cmd, 8'h01);
    send(8'h1C, 0);
    watch(12, 3, 8'h01);
    send(8'hF0, 0);
    send(8'h1C, 0);
    watch(12, 0, 8'h00);
    check("release_cmd", cmd, 8'hFF);
    send(8'hE0, 0);
    send(8'h74, 0);
    watch(12, 3, 8'h00);
    check("right_cmd_hold", cmd, 8'h00);
    send(8'hE0, 0);
    send(8'hF0, 0);
    send(8'h74, 0);
    send(8'hE0, 0);
    send(8'h1C, 0);
    watch(12, 0, 8'h00);
    send(8'h1C, 0);
    send(8'h23, 0);
    watch(12, 0, 8'h00);
    check("both_cmd", cmd, 8'hFF);
    send(8'hF0, 0);
    send(8'h23, 0);
    watch(12, 3, 8'h01);
    send(8'hF0, 0);
    send(8'h1C, 0);
    send(8'h1C, 1);
    send(8'h1C, 2);
    send(8'h1C, 0);
    send(8'hF0, 0);
    send(8'h1C, 0);
    e0 = err_cnt;
    ps2_bit(1'b0);
    repeat (4) ps2_bit(1'b1);
    repeat (TO + 30) @(negedge clock);
    check("timeout_err", err_cnt - e0, 1);
    mext = 1'b0;
    mbrk = 1'b0;
    send(8'h23, 0);
    watch(12, 3, 8'h00);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    @(negedge clock);
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    check("midrst_cmd", cmd, 8'hFF);
    check("midrst_en", cmdEnable, 0);
    check("midrst_left", left_held, 0);
    check("midrst_right", right_held, 0);
    check("midrst_err", frame_err, 0);
    resetn = 1'b1;
    ml = 1'b0;
    mr = 1'b0;
    mext = 1'b0;
    mbrk = 1'b0;
    send(8'h1C, 0);
    watch(12, 3, 8'h01);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
